// File: rtl/qam_pkg.sv
// Shared definitions for the QAM bit packer: qam_num encodings, bits-per-symbol lookup
// and the packer state enum.
package qam_pkg;

    localparam logic [2:0] zBPSK   = 3'd0;
    localparam logic [2:0] zQPSK   = 3'd1;
    localparam logic [2:0] zQAM16  = 3'd2;
    localparam logic [2:0] zQAM64  = 3'd3;
    localparam logic [2:0] zQAM256 = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Returns 0 for unsupported modulations so callers can test support and size together.
    function automatic logic [3:0] qam_bps(input logic [2:0] qam_num);
        case (qam_num)
            zBPSK:   qam_bps = 4'd1;
            zQPSK:   qam_bps = 4'd2;
            zQAM16:  qam_bps = 4'd4;
            zQAM64:  qam_bps = 4'd6;
            zQAM256: qam_bps = 4'd8;
            default: qam_bps = 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/qam_bit_packer.sv
// Repacks encoder bytes (MSB first) into right-aligned symbols of 1/2/4/6/8 bits.
// Define QAM_PACK_STATS_EN to add the per-frame o_sym_cnt output.
module qam_bit_packer
    import qam_pkg::*;
(
    input  logic        clk,
    input  logic        xrst,
    input  logic [7:0]  i_data,
    input  logic        i_val,
    input  logic        i_last,
    output logic        o_ready,
    input  logic [2:0]  i_conf_qam_num,
    output logic [7:0]  o_data,
    output logic        o_val,
    output logic        o_last,
    input  logic        i_ready,
`ifdef QAM_PACK_STATS_EN
    output logic [15:0] o_sym_cnt,
`endif
    output logic        o_err
);

    state_t      state_reg, state_next;
    logic [15:0] buf_reg, buf_next;
    logic [4:0]  cnt_reg, cnt_next;
    logic [3:0]  bps_reg, bps_next;
    logic        bad_reg, bad_next;
    logic [7:0]  o_data_reg, o_data_next;
    logic        o_val_reg, o_val_next;
    logic        o_last_reg, o_last_next;
    logic        o_err_reg, o_err_next;

    logic        accept;
    logic        out_free;
    logic        emit;
    logic        byte_bad;
    logic [4:0]  bps5;
    logic [15:0] sym16;
    logic [15:0] buf_rem;
    logic [4:0]  cnt_rem;

    assign o_ready  = (cnt_reg <= 5'd8) && (state_reg != ST_FLUSH);
    assign accept   = i_val && o_ready;
    assign out_free = !o_val_reg || i_ready;
    assign bps5     = {1'b0, bps_reg};
    assign byte_bad = (state_reg == ST_IDLE) ? (qam_bps(i_conf_qam_num) == 4'd0) : bad_reg;

    // Buffer bits past cnt_reg are always zero, so the final short symbol is padded for free.
    assign emit  = out_free && !bad_reg && (cnt_reg != 5'd0)
                   && ((cnt_reg >= bps5) || (state_reg == ST_FLUSH));
    assign sym16 = buf_reg >> (5'd16 - bps5);

    always_comb begin
        buf_rem = buf_reg;
        cnt_rem = cnt_reg;
        if (emit) begin
            buf_rem = buf_reg << bps_reg;
            cnt_rem = (cnt_reg > bps5) ? (cnt_reg - bps5) : 5'd0;
        end
    end

    always_comb begin
        state_next  = state_reg;
        buf_next    = buf_rem;
        cnt_next    = cnt_rem;
        bps_next    = bps_reg;
        bad_next    = bad_reg;
        o_data_next = o_data_reg;
        o_val_next  = o_val_reg;
        o_last_next = o_last_reg;
        o_err_next  = 1'b0;

        if (out_free) begin
            o_val_next  = emit;
            o_last_next = 1'b0;
            if (emit) begin
                o_data_next = sym16[7:0];
                o_last_next = (state_reg == ST_FLUSH) && (cnt_reg <= bps5);
            end
        end

        if (accept && !byte_bad) begin
            buf_next = buf_rem | ({i_data, 8'h00} >> cnt_rem);
            cnt_next = cnt_rem + 5'd8;
        end

        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    bad_next   = byte_bad;
                    o_err_next = byte_bad;
                    if (!byte_bad) begin
                        bps_next = qam_bps(i_conf_qam_num);
                    end
                    state_next = i_last ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && i_last) begin
                    state_next = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // Nothing left to emit and the final symbol (if any) has been taken.
                if ((cnt_reg == 5'd0) && out_free) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (xrst) begin
            state_reg  <= ST_IDLE;
            buf_reg    <= 16'h0000;
            cnt_reg    <= 5'd0;
            bps_reg    <= 4'd1;
            bad_reg    <= 1'b0;
            o_data_reg <= 8'h00;
            o_val_reg  <= 1'b0;
            o_last_reg <= 1'b0;
            o_err_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            buf_reg    <= buf_next;
            cnt_reg    <= cnt_next;
            bps_reg    <= bps_next;
            bad_reg    <= bad_next;
            o_data_reg <= o_data_next;
            o_val_reg  <= o_val_next;
            o_last_reg <= o_last_next;
            o_err_reg  <= o_err_next;
        end
    end

    assign o_data = o_data_reg;
    assign o_val  = o_val_reg;
    assign o_last = o_last_reg;
    assign o_err  = o_err_reg;

`ifdef QAM_PACK_STATS_EN
    logic [15:0] sym_cnt_reg;

    always_ff @(posedge clk) begin
        if (xrst) begin
            sym_cnt_reg <= 16'h0000;
        end else if ((state_reg == ST_IDLE) && accept) begin
            sym_cnt_reg <= 16'h0000;
        end else if (o_val_reg && i_ready && (sym_cnt_reg != 16'hFFFF)) begin
            sym_cnt_reg <= sym_cnt_reg + 16'd1;
        end
    end

    assign o_sym_cnt = sym_cnt_reg;
`endif

endmodule

// File: doc/qam_bit_packer.md
QAM_BIT_PACKER -- requirements
Module: qam_bit_packer

Interface
REQ-001 The module SHALL have one clock, clk; reset is synchronous and active-high, on port xrst (the codebase's reset name; active-high here).
REQ-002 The module SHALL have these ports:
- clk  in  1  clock
- xrst  in  1  synchronous reset, active-high
- i_data  in  8  coded byte from the LDPC encoder; bit 7 is sent first
- i_val  in  1  i_data valid
- i_last  in  1  last byte of the frame; qualified by i_val
- o_ready  out  1  byte accepted this cycle when i_val&&o_ready
- i_conf_qam_num  in  3  0=BPSK, 1=QPSK, 2=QAM16, 3=QAM64, 4=QAM256
- o_data  out  8  symbol bits, right-aligned, unused MSBs zero; feeds modulator i_data
- o_val  out  1  o_data valid
- o_last  out  1  last symbol of the frame
- i_ready  in  1  downstream accepts o_data when o_val&&i_ready
- o_err  out  1  one-cycle pulse when a byte arrives with an unsupported qam_num

Function
REQ-003 Bits per symbol (bps) SHALL be 1/2/4/6/8 for qam_num 0/1/2/3/4; values 5-7 are unsupported.
REQ-004 Bits SHALL sit in a 16-bit MSB-first buffer with a bit count of 0..16.
REQ-005 o_ready SHALL be 1 when count<=8 and state!=FLUSH, and 0 otherwise; it is combinational from registered state only.
REQ-006 On an accepted byte, its 8 bits SHALL be appended after the existing buffered bits.
REQ-007 Symbol emission: when the output register is free (!o_val || i_ready) and count>=bps, the module SHALL load the top bps buffer bits into o_data[bps-1:0] and drop them from the buffer.
REQ-008 Accept and emit SHALL happen in the same cycle when both conditions hold, with no bubble.
REQ-009 Latency SHALL be one cycle: a byte accepted at edge N gives o_val=1 after edge N+1 if the output register is free.
REQ-010 o_data, o_val and o_last SHALL hold stable while o_val&&!i_ready.
REQ-011 The state machine SHALL have three states:
- IDLE -> RUN on the first accepted byte; bps is latched from i_conf_qam_num on that byte.
- RUN -> FLUSH on an accepted byte with i_last=1.
- FLUSH -> IDLE after the symbol carrying the final bit has been accepted downstream.
REQ-012 bps SHALL stay frozen from IDLE until the return to IDLE; i_conf_qam_num changes mid-frame SHALL be ignored.
REQ-013 In FLUSH, if 0<count<bps, the remaining bits SHALL be zero-padded at the LSB end and emitted as one final symbol; if count==0 after the last full symbol, no extra symbol SHALL be emitted.
REQ-014 o_last SHALL be 1 on exactly the symbol that carries the frame's final bit.
REQ-015 A frame of one byte with i_last=1 SHALL go IDLE->FLUSH directly.
REQ-016 Unsupported qam_num latched at frame start: bytes SHALL be accepted and discarded until i_last, o_err SHALL pulse on the first byte, no symbols SHALL be produced, and the block SHALL return to IDLE.

Reset
REQ-017 While xrst=1 at a clk edge: state=IDLE, buffer=0, count=0, bps=1, o_data=0, o_val=0, o_last=0, o_err=0.
REQ-018 Reset mid-frame SHALL discard all buffered bits and any pending symbol; o_ready SHALL be 1 on the first cycle after reset.

Configuration
REQ-019 With QAM_PACK_STATS_EN defined, the module SHALL add output o_sym_cnt[15:0]:
- counts symbols accepted downstream in the current frame, saturating at 16'hFFFF;
- cleared to 0 on reset and when a new frame starts;
- holds its value in IDLE.
REQ-020 Without QAM_PACK_STATS_EN, the o_sym_cnt port and its counter SHALL be absent.

Structure
REQ-021 The shared package qam_pkg SHALL hold the qam_num encodings (zBPSK..zQAM256), the bps lookup function, and the state enum.
REQ-022 The design SHALL be a single module; no sub-module is required.

Verification
REQ-023 QPSK, byte 0xB4 with i_last, i_ready=1 -> o_data 0x02, 0x03, 0x01, 0x00 on consecutive cycles, o_last on 0x00.
REQ-024 QAM64, bytes 0xFF, 0x00, 0xAA (last) back-to-back -> 0x3F, 0x30, 0x02, 0x2A, o_last on 0x2A, no pad symbol.
REQ-025 QAM64, single byte 0xC3 with i_last -> 0x30, then padded 0x30 with o_last=1.
REQ-026 BPSK, byte 0x80, i_ready held 0 for 3 cycles -> o_data=0x01, o_val=1 stable throughout; o_ready drops to 0 while count>8.
REQ-027 QAM16 stream with xrst pulsed after 1 symbol -> o_val=0 next cycle; a new frame 0x5A gives 0x05, 0x0A.
REQ-028 qam_num=6, bytes 0x12, 0x34 (last) -> o_err pulses once, o_val never 1, state back to IDLE.
